// File: rtl/vta_mem_responder.sv
// Memory responder for the VTA DPI memory interface: accepts read/write bursts
// from an accelerator-side initiator and serves them from an internal word array.
module vta_mem_responder #(
  parameter int unsigned LEN_BITS       = 8,
  parameter int unsigned ADDR_BITS      = 64,
  parameter int unsigned DATA_BITS      = 64,
  parameter int unsigned MEM_DEPTH_LOG2 = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dpi_req_valid,
  input  logic                 dpi_req_opcode,
  input  logic [LEN_BITS-1:0]  dpi_req_len,
  input  logic [ADDR_BITS-1:0] dpi_req_addr,
  input  logic                 dpi_wr_valid,
  input  logic [DATA_BITS-1:0] dpi_wr_bits,
  output logic                 dpi_rd_valid,
  output logic [DATA_BITS-1:0] dpi_rd_bits,
  input  logic                 dpi_rd_ready,
  output logic                 busy,
  output logic                 err_overlap
);

  localparam int unsigned BYTE_SHIFT = $clog2(DATA_BITS / 8);
  localparam int unsigned DEPTH      = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned CNT_BITS   = LEN_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  logic [DATA_BITS-1:0]      r_mem [DEPTH];
  state_t                    r_state, w_state_nxt;
  logic [MEM_DEPTH_LOG2-1:0] r_idx, w_idx_nxt, w_req_idx;
  logic [CNT_BITS-1:0]       r_cnt, w_cnt_nxt;
  logic                      r_rd_valid, w_rd_valid_nxt;
  logic [DATA_BITS-1:0]      r_rd_bits;
  logic                      r_busy, r_err, w_err_nxt;
  logic                      w_rd_load, w_mem_we;
  logic [ADDR_BITS-1:0]      w_addr_words;
  logic                      w_unused_addr;

  // Byte address to word index; bits above the array depth are dropped.
  assign w_addr_words  = dpi_req_addr >> BYTE_SHIFT;
  assign w_req_idx     = w_addr_words[MEM_DEPTH_LOG2-1:0];
  assign w_unused_addr = ^w_addr_words;

  assign dpi_rd_valid = r_rd_valid;
  assign dpi_rd_bits  = r_rd_bits;
  assign busy         = r_busy;
  assign err_overlap  = r_err;

  // Next-state logic: request acceptance, read beat sequencing, write absorption.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_rd_valid_nxt = r_rd_valid;
    w_err_nxt      = r_err;
    w_rd_load      = 1'b0;
    w_mem_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dpi_req_valid) begin
          w_idx_nxt   = w_req_idx;
          w_cnt_nxt   = CNT_BITS'(dpi_req_len) + CNT_BITS'(1);
          w_state_nxt = dpi_req_opcode ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (dpi_req_valid) w_err_nxt = 1'b1;
        // r_cnt counts beats not yet loaded into the output register.
        if (!r_rd_valid || dpi_rd_ready) begin
          if (r_cnt != CNT_BITS'(0)) begin
            w_rd_load      = 1'b1;
            w_rd_valid_nxt = 1'b1;
            w_idx_nxt      = r_idx + MEM_DEPTH_LOG2'(1);
            w_cnt_nxt      = r_cnt - CNT_BITS'(1);
          end else begin
            w_rd_valid_nxt = 1'b0;
            w_state_nxt    = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        if (dpi_req_valid) w_err_nxt = 1'b1;
        if (dpi_wr_valid) begin
          w_mem_we  = 1'b1;
          w_idx_nxt = r_idx + MEM_DEPTH_LOG2'(1);
          w_cnt_nxt = r_cnt - CNT_BITS'(1);
          if (r_cnt == CNT_BITS'(1)) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters and registered outputs; busy trails the state by one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_bits  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_busy     <= (r_state != S_IDLE);
      r_err      <= w_err_nxt;
      if (w_rd_load) r_rd_bits <= r_mem[r_idx];
    end
  end

  // Word array; contents survive reset, writes are suppressed while in reset.
  always_ff @(posedge clock) begin
    if (w_mem_we && !reset) r_mem[r_idx] <= dpi_wr_bits;
  end

endmodule

// File: tb/tb_vta_mem_responder.sv
// Self-checking bench for vta_mem_responder with a word-array reference model.
module tb_vta_mem_responder;

  localparam int unsigned LB    = 8;
  localparam int unsigned AB    = 64;
  localparam int unsigned DB    = 64;
  localparam int unsigned ML    = 12;
  localparam int unsigned DEPTH = 1 << ML;

  logic          clock, reset;
  logic          dpi_req_valid, dpi_req_opcode;
  logic [LB-1:0] dpi_req_len;
  logic [AB-1:0] dpi_req_addr;
  logic          dpi_wr_valid;
  logic [DB-1:0] dpi_wr_bits;
  logic          dpi_rd_valid;
  logic [DB-1:0] dpi_rd_bits;
  logic          dpi_rd_ready;
  logic          busy, err_overlap;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] model [int];

  vta_mem_responder #(.LEN_BITS(LB), .ADDR_BITS(AB), .DATA_BITS(DB), .MEM_DEPTH_LOG2(ML)) dut (
    .clock(clock), .reset(reset),
    .dpi_req_valid(dpi_req_valid), .dpi_req_opcode(dpi_req_opcode),
    .dpi_req_len(dpi_req_len), .dpi_req_addr(dpi_req_addr),
    .dpi_wr_valid(dpi_wr_valid), .dpi_wr_bits(dpi_wr_bits),
    .dpi_rd_valid(dpi_rd_valid), .dpi_rd_bits(dpi_rd_bits), .dpi_rd_ready(dpi_rd_ready),
    .busy(busy), .err_overlap(err_overlap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int widx(input logic [63:0] a);
    return int'((a >> 3) & 64'(DEPTH - 1));
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input bit op, input logic [63:0] addr, input int len);
    dpi_req_valid  = 1'b1;
    dpi_req_opcode = op;
    dpi_req_len    = LB'(len);
    dpi_req_addr   = addr;
    tick();
    dpi_req_valid  = 1'b0;
  endtask

  // Write burst with optional idle gap before each beat; updates the model.
  task automatic do_write(input logic [63:0] addr, input int len, input int gap,
                          input logic [63:0] words[$]);
    int base;
    base = widx(addr);
    issue(1'b1, addr, len);
    for (int i = 0; i <= len; i++) begin
      repeat (gap) begin
        dpi_wr_valid = 1'b0;
        dpi_wr_bits  = rnd64();
        tick();
      end
      dpi_wr_valid = 1'b1;
      dpi_wr_bits  = words[i];
      model[(base + i) % DEPTH] = words[i];
      tick();
    end
    dpi_wr_valid = 1'b0;
  endtask

  // Read burst; mode 0 ready always, 1 ready from pattern (then 1), 2 random ready.
  task automatic do_read(input logic [63:0] addr, input int len, input int mode,
                         input logic [31:0] pat, input int pat_len, input int stop_after,
                         input bit skip_issue,
                         output logic [63:0] got[$], output int valid_cycles,
                         output int first_lat, output bit stable_ok, output bit timeout);
    int cyc, p, budget;
    bit r, held;
    logic [63:0] hv;
    got.delete();
    valid_cycles = 0; first_lat = -1; stable_ok = 1'b1; timeout = 1'b0;
    cyc = 0; p = 0; held = 1'b0; hv = '0;
    budget = (len + 1) * 10 + 20;
    if (!skip_issue) issue(1'b0, addr, len);
    while (got.size() < len + 1 && got.size() < stop_after) begin
      if (cyc >= budget) begin
        timeout = 1'b1;
        break;
      end
      r = 1'b0;
      if (dpi_rd_valid) begin
        if (first_lat < 0) first_lat = cyc;
        valid_cycles++;
        if (held && dpi_rd_bits !== hv) stable_ok = 1'b0;
        case (mode)
          0:       r = 1'b1;
          1:       r = (p < pat_len) ? pat[p] : 1'b1;
          default: r = 1'($urandom_range(0, 1));
        endcase
        p++;
        if (r) begin
          got.push_back(dpi_rd_bits);
          held = 1'b0;
        end else begin
          held = 1'b1;
          hv   = dpi_rd_bits;
        end
      end
      dpi_rd_ready = r;
      tick();
      cyc++;
    end
    dpi_rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (dpi_rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", dpi_rd_valid); end
    n_cmp++; if (dpi_rd_bits !== 64'h0) begin n_bad++; $display("FAIL reset_rd_bits: got %h want 0", dpi_rd_bits); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (err_overlap !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_overlap); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    logic [63:0] a[$], got[$];
    int vc, fl; bit st, to;
    for (int i = 0; i < 4; i++) a.push_back(rnd64());
    do_write(64'h40, 3, 0, a);
    do_read(64'h40, 3, 0, '0, 0, 1000, 1'b0, got, vc, fl, st, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL wr_rd_timeout: got %b want 0", to); end
    n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL wr_rd_beats: got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got[i] !== a[i]) begin n_bad++; $display("FAIL wr_rd_data[%0d]: got %h want %h", i, got[i], a[i]); end
    end
    n_cmp++; if (vc != 4) begin n_bad++; $display("FAIL wr_rd_valid_cycles: got %0d want 4", vc); end
    n_cmp++; if (fl != 1) begin n_bad++; $display("FAIL wr_rd_first_latency: got %0d want 1", fl); end
    n_cmp++; if (dpi_rd_valid !== 1'b0) begin n_bad++; $display("FAIL wr_rd_valid_end: got %b want 0", dpi_rd_valid); end
  endtask

  task automatic test_backpressure();
    logic [63:0] a[$], got[$], addr;
    int vc, fl, len, base; bit st, to;
    addr = rnd64();
    for (int i = 0; i < 3; i++) a.push_back(rnd64());
    do_write(addr, 2, 0, a);
    do_read(addr, 2, 1, 32'b101001, 6, 1000, 1'b0, got, vc, fl, st, to);
    n_cmp++; if (got.size() != 3 || to) begin n_bad++; $display("FAIL bp_handshakes: got %0d want 3 (timeout %b)", got.size(), to); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (got[i] !== a[i]) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, got[i], a[i]); end
    end
    n_cmp++; if (!st) begin n_bad++; $display("FAIL bp_stable: beat changed while stalled"); end
    n_cmp++; if (vc != 6) begin n_bad++; $display("FAIL bp_valid_cycles: got %0d want 6", vc); end
    n_cmp++; if (dpi_rd_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_end: got %b want 0", dpi_rd_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy_hold: got %b want 1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_busy_drop: got %b want 0", busy); end
    // Random backpressure over random bursts.
    for (int k = 0; k < 4; k++) begin
      a.delete();
      addr = rnd64();
      len  = $urandom_range(0, 9);
      base = widx(addr);
      for (int i = 0; i <= len; i++) a.push_back(rnd64());
      do_write(addr, len, $urandom_range(0, 2), a);
      do_read(addr, len, 2, '0, 0, 1000, 1'b0, got, vc, fl, st, to);
      n_cmp++; if (!st || to || got.size() != len + 1) begin n_bad++; $display("FAIL bp_rand_shape[%0d]: beats %0d want %0d stable %b timeout %b", k, got.size(), len + 1, st, to); end
      for (int i = 0; i <= len; i++) begin
        n_cmp++; if (got[i] !== model[(base + i) % DEPTH]) begin n_bad++; $display("FAIL bp_rand_data[%0d.%0d]: got %h want %h", k, i, got[i], model[(base + i) % DEPTH]); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] x, y, a[$], got[$], top;
    int vc, fl; bit st, to;
    x = rnd64(); y = rnd64();
    a.push_back(x); a.push_back(y);
    top = 64'(DEPTH - 1) * 64'd8;
    do_write(top, 1, 0, a);
    do_read(64'h0, 0, 0, '0, 0, 1000, 1'b0, got, vc, fl, st, to);
    n_cmp++; if (got.size() != 1 || got[0] !== y) begin n_bad++; $display("FAIL wrap_idx0: got %h want %h", got[0], y); end
    do_read(top, 0, 0, '0, 0, 1000, 1'b0, got, vc, fl, st, to);
    n_cmp++; if (got.size() != 1 || got[0] !== x) begin n_bad++; $display("FAIL wrap_last: got %h want %h", got[0], x); end
    do_read(top, 1, 0, '0, 0, 1000, 1'b0, got, vc, fl, st, to);
    n_cmp++; if (got.size() != 2 || got[0] !== x || got[1] !== y) begin n_bad++; $display("FAIL wrap_burst: got %h,%h want %h,%h", got[0], got[1], x, y); end
  endtask

  task automatic test_overlap();
    logic [63:0] a[$], got[$], addr;
    int vc, fl; bit st, to;
    addr = 64'h1000;
    for (int i = 0; i < 4; i++) a.push_back(rnd64());
    do_write(addr, 3, 0, a);
    n_cmp++; if (err_overlap !== 1'b0) begin n_bad++; $display("FAIL ovl_pre: got %b want 0", err_overlap); end
    issue(1'b0, addr, 3);
    issue(1'b1, 64'h40, 0);
    n_cmp++; if (err_overlap !== 1'b1) begin n_bad++; $display("FAIL ovl_set: got %b want 1", err_overlap); end
    do_read(addr, 3, 2, '0, 0, 1000, 1'b1, got, vc, fl, st, to);
    n_cmp++; if (got.size() != 4 || to || !st) begin n_bad++; $display("FAIL ovl_shape: beats %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got[i] !== a[i]) begin n_bad++; $display("FAIL ovl_data[%0d]: got %h want %h", i, got[i], a[i]); end
    end
    tick(); tick();
    n_cmp++; if (err_overlap !== 1'b1) begin n_bad++; $display("FAIL ovl_sticky: got %b want 1", err_overlap); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovl_idle: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] a[$], got[$], addr;
    int vc, fl; bit st, to;
    addr = 64'h2000;
    for (int i = 0; i < 4; i++) a.push_back(rnd64());
    do_write(addr, 3, 0, a);
    do_read(addr, 3, 0, '0, 0, 2, 1'b0, got, vc, fl, st, to);
    n_cmp++; if (got.size() != 2 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre: beats %0d busy %b want 2/1", got.size(), busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (dpi_rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", dpi_rd_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_cmp++; if (err_overlap !== 1'b0) begin n_bad++; $display("FAIL rst_mid_err: got %b want 0", err_overlap); end
    do_read(addr, 3, 0, '0, 0, 1000, 1'b0, got, vc, fl, st, to);
    n_cmp++; if (got.size() != 4 || to) begin n_bad++; $display("FAIL rst_mid_reread: beats %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got[i] !== a[i]) begin n_bad++; $display("FAIL rst_mid_data[%0d]: got %h want %h", i, got[i], a[i]); end
    end
  endtask

  task automatic test_len0_gap();
    logic [63:0] a[$], got[$], addr, n;
    int vc, fl; bit st, to;
    addr = 64'h3008;
    a.push_back(rnd64()); a.push_back(rnd64());
    do_write(addr, 1, 0, a);
    n = rnd64();
    // Data present at the accepting edge must not count as a beat.
    dpi_wr_valid = 1'b1;
    dpi_wr_bits  = rnd64();
    issue(1'b1, addr, 0);
    dpi_wr_valid = 1'b0;
    repeat (5) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL gap_busy: got %b want 1", busy); end
    dpi_wr_valid = 1'b1;
    dpi_wr_bits  = n;
    model[widx(addr)] = n;
    tick();
    // Stray beats while idle must leave the array untouched.
    repeat (3) begin
      dpi_wr_bits = rnd64();
      tick();
    end
    dpi_wr_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL gap_idle: busy %b want 0", busy); end
    do_read(addr, 1, 0, '0, 0, 1000, 1'b0, got, vc, fl, st, to);
    n_cmp++; if (got.size() != 2 || got[0] !== n) begin n_bad++; $display("FAIL gap_word: got %h want %h", got[0], n); end
    n_cmp++; if (got[1] !== a[1]) begin n_bad++; $display("FAIL gap_neighbour: got %h want %h", got[1], a[1]); end
  endtask

  task automatic test_max_len();
    logic [63:0] a[$], got[$], addr;
    int vc, fl, base, nb; bit st, to;
    addr = 64'(DEPTH - 100) * 64'd8;
    base = widx(addr);
    for (int i = 0; i < 256; i++) a.push_back(rnd64());
    do_write(addr, 255, 0, a);
    do_read(addr, 255, 2, '0, 0, 1000, 1'b0, got, vc, fl, st, to);
    n_cmp++; if (got.size() != 256 || to || !st) begin n_bad++; $display("FAIL max_shape: beats %0d want 256", got.size()); end
    nb = 0;
    for (int i = 0; i < 256; i++) if (got[i] !== model[(base + i) % DEPTH]) nb++;
    n_cmp++; if (nb != 0) begin n_bad++; $display("FAIL max_data: %0d wrong beats want 0", nb); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a[$], got[$], addr;
    int vc, fl, len, base; bit st, to;
    for (int k = 0; k < 16; k++) begin
      addr = {52'h0, 12'($urandom_range(0, 511))};
      len  = $urandom_range(0, 15);
      base = widx(addr);
      if ($urandom_range(0, 1) == 1) begin
        a.delete();
        for (int i = 0; i <= len; i++) a.push_back(rnd64());
        do_write(addr, len, 0, a);
      end else begin
        do_read(addr, len, 2, '0, 0, 1000, 1'b0, got, vc, fl, st, to);
        n_cmp++; if (got.size() != len + 1 || to || !st) begin n_bad++; $display("FAIL b2b_shape[%0d]: beats %0d want %0d", k, got.size(), len + 1); end
        for (int i = 0; i <= len; i++) begin
          if (model.exists((base + i) % DEPTH)) begin
            n_cmp++; if (got[i] !== model[(base + i) % DEPTH]) begin n_bad++; $display("FAIL b2b_data[%0d.%0d]: got %h want %h", k, i, got[i], model[(base + i) % DEPTH]); end
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    dpi_req_valid = 1'b0; dpi_req_opcode = 1'b0; dpi_req_len = '0; dpi_req_addr = '0;
    dpi_wr_valid = 1'b0; dpi_wr_bits = '0; dpi_rd_ready = 1'b0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_wrap();
    test_overlap();
    test_reset_mid();
    test_len0_gap();
    test_max_len();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
